disp_mux_driver: RTL and testbench

Downstream stage of the routing/error-correction block. Consumes its four 4-bit display words (d_disp0..d_disp3) and drives a 4-digit, common-anode seven-segment display by time-multiplexing. Input words are snapshotted once per frame so the display never shows a partially updated set of digits.

---
 rtl/disp_mux_driver.sv | 137 +++++++++++++
 tb/tb_disp_mux_driver.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/disp_mux_driver.sv
// Four-digit common-anode seven-segment scanner. Digit values are snapshotted
// once per frame so a scan never mixes old and new digits.
module disp_mux_driver #(
    parameter int unsigned REFRESH_CNT = 4,
    parameter int unsigned CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:4] d_disp0,
    input  logic [1:4] d_disp1,
    input  logic [1:4] d_disp2,
    input  logic [1:4] d_disp3,
    input  logic       en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] digit_idx,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);
    localparam logic [3:0]       AN_OFF   = 4'b1111;
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       shadow_q [4];
    logic [3:0]       shadow_d [4];
    logic             load_pending_q, load_pending_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic             frame_done_q, frame_done_d;

    logic [3:0]       din [4];
    logic             dwell_last;
    logic             wrap;

    // Segment order is {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign din[0] = d_disp0;
    assign din[1] = d_disp1;
    assign din[2] = d_disp2;
    assign din[3] = d_disp3;

    assign dwell_last = (cnt_q == CNT_LAST);
    assign wrap       = en && dwell_last && (idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            idx_q          <= 2'd0;
            load_pending_q <= 1'b1;
            an_q           <= AN_OFF;
            seg_q          <= SEG_OFF;
            digit_idx_q    <= 2'd0;
            frame_done_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 4'h0;
            end
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            load_pending_q <= load_pending_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            digit_idx_q    <= digit_idx_d;
            frame_done_q   <= frame_done_d;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    // Dwell counter and digit index only move while enabled.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (en) begin
            if (dwell_last) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // The first edge out of reset and every frame wrap refresh the snapshot.
    always_comb begin
        shadow_d       = shadow_q;
        load_pending_d = 1'b0;
        frame_done_d   = wrap;
        if (wrap || load_pending_q) begin
            shadow_d = din;
        end
    end

    always_comb begin
        digit_idx_d = idx_q;
        an_d        = AN_OFF;
        seg_d       = SEG_OFF;
        if (en) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = hex7(shadow_q[idx_q]);
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = 1'b1;
    assign digit_idx  = digit_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_mux_driver.sv
// Directed bench for disp_mux_driver: one REFRESH_CNT=4 and one REFRESH_CNT=1
// instance share stimulus; a frame-position model feeds an expected queue.
module tb_disp_mux_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:4] d0, d1, d2, d3;

    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [1:0] idx_a, idx_b;
    logic       fd_a, fd_b;

    always #5 clk = ~clk;

    disp_mux_driver #(.REFRESH_CNT(4), .CNT_W(17)) u_dut (
        .clk(clk), .rst(rst),
        .d_disp0(d0), .d_disp1(d1), .d_disp2(d2), .d_disp3(d3),
        .en(en), .an(an_a), .seg(seg_a), .dp(dp_a),
        .digit_idx(idx_a), .frame_done(fd_a)
    );

    disp_mux_driver #(.REFRESH_CNT(1), .CNT_W(17)) u_dut1 (
        .clk(clk), .rst(rst),
        .d_disp0(d0), .d_disp1(d1), .d_disp2(d2), .d_disp3(d3),
        .en(en), .an(an_b), .seg(seg_b), .dp(dp_b),
        .digit_idx(idx_b), .frame_done(fd_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [13:0] exp_q  [$];
    logic [13:0] exp1_q [$];

    logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          pos_a = 0, pos_b = 0;
    logic [15:0] sh_a = '0, sh_b = '0;
    logic        pend_a = 1'b1, pend_b = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Expected word = {an, seg, digit_idx, frame_done} for the coming edge.
    task automatic model_step(input int r, inout int p, inout logic [15:0] s,
                              inout logic pd, output logic [13:0] e);
        int dig;
        dig = (p / r) % 4;
        if (rst) begin
            e  = {4'hF, 7'h7F, 2'd0, 1'b0};
            p  = 0;
            s  = '0;
            pd = 1'b1;
        end else begin
            if (en)
                e = {4'(~(4'b0001 << dig)), hex_tbl[s[dig*4 +: 4]], dig[1:0], (p == 4*r - 1)};
            else
                e = {4'hF, 7'h7F, dig[1:0], 1'b0};
            if (pd || (en && p == 4*r - 1))
                s = {d3, d2, d1, d0};
            pd = 1'b0;
            if (en)
                p = (p + 1) % (4*r);
        end
    endtask

    task automatic cycle();
        logic [13:0] e;
        logic [13:0] got;
        model_step(4, pos_a, sh_a, pend_a, e);
        exp_q.push_back(e);
        model_step(1, pos_b, sh_b, pend_b, e);
        exp1_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("r4_an",  32'(an_a),  32'(got[13:10]));
        check("r4_seg", 32'(seg_a), 32'(got[9:3]));
        check("r4_idx", 32'(idx_a), 32'(got[2:1]));
        check("r4_fd",  32'(fd_a),  32'(got[0]));
        check("r4_dp",  32'(dp_a),  32'(1));
        got = exp1_q.pop_front();
        check("r1_an",  32'(an_b),  32'(got[13:10]));
        check("r1_seg", 32'(seg_b), 32'(got[9:3]));
        check("r1_idx", 32'(idx_b), 32'(got[2:1]));
        check("r1_fd",  32'(fd_b),  32'(got[0]));
    endtask

    initial begin
        // Startup: two reset cycles, one load edge with en low, then two frames.
        rst = 1'b1; en = 1'b0;
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        en = 1'b1;
        repeat (32) cycle();

        // All digits 'b'; then digit 2 changes mid-frame and must wait a frame.
        d0 = 4'hB; d1 = 4'hB; d2 = 4'hB; d3 = 4'hB;
        repeat (16) cycle();
        for (int k = 0; k < 16; k++) begin
            if (k == 4) d2 = 4'h0;
            cycle();
        end
        repeat (16) cycle();

        // Decode sweep on digit 0, one value per frame.
        for (int v = 0; v < 17; v++) begin
            d0 = 4'(v % 16);
            repeat (16) cycle();
        end

        // Enable gating in the middle of digit 2.
        repeat (9) cycle();
        en = 1'b0;
        repeat (10) cycle();
        en = 1'b1;
        repeat (7) cycle();

        // Reset at idx=3, cnt=2 with en still high, then restart with new inputs.
        repeat (14) cycle();
        d0 = 4'h5; d1 = 4'h6; d2 = 4'h7; d3 = 4'h8;
        rst = 1'b1;
        cycle();
        rst = 1'b0; en = 1'b0;
        cycle();
        en = 1'b1;
        repeat (16) cycle();

        // Clean restart focused on the single-cycle dwell instance.
        rst = 1'b1;
        cycle();
        rst = 1'b0; en = 1'b0;
        cycle();
        en = 1'b1;
        repeat (12) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
